// File: rtl/big_endian_mem_arbiter.sv
// ============================================================================
// Module   : big_endian_mem_arbiter
// Brief    : Two-port request arbiter/sequencer for a big-endian word memory.
//            Define MEM_ARB_ROUND_ROBIN_EN for round-robin, else A has priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module big_endian_mem_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   // requester A
   input  logic              a_req_valid,
   output logic              a_req_ready,
   input  logic              a_req_we,
   input  logic [ADDR_W-1:0] a_req_addr,
   input  logic [1:0]        a_req_byte_sel,
   input  logic [DATA_W-1:0] a_req_wdata,
   output logic              a_rsp_valid,
   input  logic              a_rsp_ready,
   output logic [DATA_W-1:0] a_rsp_rdata,
   output logic [7:0]        a_rsp_byte,
   // requester B
   input  logic              b_req_valid,
   output logic              b_req_ready,
   input  logic              b_req_we,
   input  logic [ADDR_W-1:0] b_req_addr,
   input  logic [1:0]        b_req_byte_sel,
   input  logic [DATA_W-1:0] b_req_wdata,
   output logic              b_rsp_valid,
   input  logic              b_rsp_ready,
   output logic [DATA_W-1:0] b_rsp_rdata,
   output logic [7:0]        b_rsp_byte,
   // memory command port
   output logic [ADDR_W-1:0] mem_addr,
   output logic [1:0]        mem_byte_sel,
   output logic              mem_we,
   output logic              mem_re,
   output logic [DATA_W-1:0] mem_data,
   input  logic [DATA_W-1:0] mem_read_data,
   input  logic [7:0]        mem_data_out_byte
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ISSUE = 2'd1;
   localparam logic [1:0] S_RESP  = 2'd2;

   localparam logic C_OWN_A = 1'b0;
   localparam logic C_OWN_B = 1'b1;

   logic [1:0]        r_state;
   logic [1:0]        w_state_nxt;
   logic              r_owner;
   logic              r_cmd_we;
   logic [ADDR_W-1:0] r_cmd_addr;
   logic [1:0]        r_cmd_bsel;
   logic [DATA_W-1:0] r_cmd_wdata;
   logic              w_grant_a;
   logic              w_grant_b;
   logic              w_accept;
   logic              w_owner_rsp_ready;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic r_last_grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_grant <= C_OWN_B;
      end else if (w_accept) begin
         r_last_grant <= w_grant_b;
      end
   end

   // On contention the requester that was not served last wins
   assign w_grant_b = b_req_valid & (~a_req_valid | (r_last_grant == C_OWN_A));
`else
   assign w_grant_b = b_req_valid & ~a_req_valid;
`endif

   assign w_grant_a         = a_req_valid & ~w_grant_b;
   assign w_accept          = (r_state == S_IDLE) & (w_grant_a | w_grant_b);
   assign w_owner_rsp_ready = (r_owner == C_OWN_B) ? b_rsp_ready : a_rsp_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_owner     <= C_OWN_A;
         r_cmd_we    <= 1'b0;
         r_cmd_addr  <= '0;
         r_cmd_bsel  <= 2'b00;
         r_cmd_wdata <= '0;
      end else if (w_accept) begin
         r_owner     <= w_grant_b;
         r_cmd_we    <= w_grant_b ? b_req_we       : a_req_we;
         r_cmd_addr  <= w_grant_b ? b_req_addr     : a_req_addr;
         r_cmd_bsel  <= w_grant_b ? b_req_byte_sel : a_req_byte_sel;
         r_cmd_wdata <= w_grant_b ? b_req_wdata    : a_req_wdata;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = S_ISSUE;
         S_ISSUE: w_state_nxt = S_RESP;
         S_RESP:  if (w_owner_rsp_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      a_req_ready  = 1'b0;
      b_req_ready  = 1'b0;
      a_rsp_valid  = 1'b0;
      b_rsp_valid  = 1'b0;
      a_rsp_rdata  = '0;
      b_rsp_rdata  = '0;
      a_rsp_byte   = 8'h00;
      b_rsp_byte   = 8'h00;
      mem_addr     = '0;
      mem_byte_sel = 2'b00;
      mem_we       = 1'b0;
      mem_re       = 1'b0;
      mem_data     = '0;
      case (r_state)
         S_IDLE: begin
            a_req_ready = w_grant_a;
            b_req_ready = w_grant_b;
         end
         S_ISSUE: begin
            mem_addr     = r_cmd_addr;
            mem_byte_sel = r_cmd_bsel;
            mem_data     = r_cmd_wdata;
            mem_we       = r_cmd_we;
            mem_re       = ~r_cmd_we;
         end
         S_RESP: begin
            // Memory read outputs hold in RESP since mem_re is low
            if (r_owner == C_OWN_A) begin
               a_rsp_valid = 1'b1;
               if (!r_cmd_we) begin
                  a_rsp_rdata = mem_read_data;
                  a_rsp_byte  = mem_data_out_byte;
               end
            end else begin
               b_rsp_valid = 1'b1;
               if (!r_cmd_we) begin
                  b_rsp_rdata = mem_read_data;
                  b_rsp_byte  = mem_data_out_byte;
               end
            end
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire

// File: tb/tb_big_endian_mem_arbiter.sv
// ============================================================================
// Module   : tb_big_endian_mem_arbiter
// Brief    : Self-checking bench for big_endian_mem_arbiter with memory model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_big_endian_mem_arbiter;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        a_req_valid = 0, a_req_we = 0, a_rsp_ready = 1;
   logic [15:0] a_req_addr = 0;
   logic [1:0]  a_req_byte_sel = 0;
   logic [31:0] a_req_wdata = 0;
   logic        b_req_valid = 0, b_req_we = 0, b_rsp_ready = 1;
   logic [15:0] b_req_addr = 0;
   logic [1:0]  b_req_byte_sel = 0;
   logic [31:0] b_req_wdata = 0;
   logic        a_req_ready, a_rsp_valid, b_req_ready, b_rsp_valid;
   logic [31:0] a_rsp_rdata, b_rsp_rdata;
   logic [7:0]  a_rsp_byte, b_rsp_byte;
   logic [15:0] mem_addr;
   logic [1:0]  mem_byte_sel;
   logic        mem_we, mem_re;
   logic [31:0] mem_data;
   logic [31:0] mem_read_data = 0;
   logic [7:0]  mem_data_out_byte = 0;

   logic [31:0] mem     [0:65535];
   logic [31:0] ref_mem [0:65535];
   bit          ref_last;
   int          checks = 0;
   int          errors = 0;

   always #5 clk = ~clk;

   big_endian_mem_arbiter #(.ADDR_W(16), .DATA_W(32)) dut (
      .clk(clk), .rst_n(rst_n),
      .a_req_valid(a_req_valid), .a_req_ready(a_req_ready), .a_req_we(a_req_we),
      .a_req_addr(a_req_addr), .a_req_byte_sel(a_req_byte_sel), .a_req_wdata(a_req_wdata),
      .a_rsp_valid(a_rsp_valid), .a_rsp_ready(a_rsp_ready), .a_rsp_rdata(a_rsp_rdata),
      .a_rsp_byte(a_rsp_byte),
      .b_req_valid(b_req_valid), .b_req_ready(b_req_ready), .b_req_we(b_req_we),
      .b_req_addr(b_req_addr), .b_req_byte_sel(b_req_byte_sel), .b_req_wdata(b_req_wdata),
      .b_rsp_valid(b_rsp_valid), .b_rsp_ready(b_rsp_ready), .b_rsp_rdata(b_rsp_rdata),
      .b_rsp_byte(b_rsp_byte),
      .mem_addr(mem_addr), .mem_byte_sel(mem_byte_sel), .mem_we(mem_we), .mem_re(mem_re),
      .mem_data(mem_data), .mem_read_data(mem_read_data), .mem_data_out_byte(mem_data_out_byte)
   );

   // Big-endian memory: byte lane 0 is bits 31:24
   always @(posedge clk) begin
      if (mem_we) mem[mem_addr] <= mem_data;
      if (mem_re) begin
         mem_read_data     <= mem[mem_addr];
         mem_data_out_byte <= be_byte(mem[mem_addr], mem_byte_sel);
      end
   end

   function automatic logic [7:0] be_byte(input logic [31:0] w, input logic [1:0] bs);
      logic [31:0] sh;
      sh = w >> (8 * (3 - int'(bs)));
      return sh[7:0];
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input bit port, input bit v, input bit we, input logic [15:0] addr,
                          input logic [1:0] bs, input logic [31:0] wd);
      if (port) begin
         b_req_valid = v; b_req_we = we; b_req_addr = addr; b_req_byte_sel = bs; b_req_wdata = wd;
      end else begin
         a_req_valid = v; a_req_we = we; a_req_addr = addr; a_req_byte_sel = bs; a_req_wdata = wd;
      end
   endtask

   // One isolated request with rsp_ready high; starts and ends #1 after posedge
   task automatic txn(input bit port, input bit we, input logic [15:0] addr, input logic [1:0] bs,
                      input logic [31:0] wd, output logic [31:0] rd, output logic [7:0] by);
      int cnt;
      logic [31:0] exp_w;
      exp_w = we ? 32'h0 : ref_mem[addr];
      set_req(port, 1'b1, we, addr, bs, wd);
      cnt = 0;
      @(negedge clk);
      while (!(port ? b_req_ready : a_req_ready) && cnt < 20) begin
         @(negedge clk);
         cnt++;
      end
      chk("accept_in_time", 32'(cnt < 20), 32'd1);
      @(posedge clk); #1;
      set_req(port, 1'b0, 1'b0, 16'h0, 2'b00, 32'h0);
      @(negedge clk);
      chk("issue_rsp_valid", 32'(port ? b_rsp_valid : a_rsp_valid), 32'd0);
      chk("issue_mem_we", 32'(mem_we), 32'(we));
      chk("issue_mem_re", 32'(mem_re), 32'(!we));
      chk("issue_mem_addr", 32'(mem_addr), 32'(addr));
      @(negedge clk);
      rd = port ? b_rsp_rdata : a_rsp_rdata;
      by = port ? b_rsp_byte : a_rsp_byte;
      chk("resp_valid_lat2", 32'(port ? b_rsp_valid : a_rsp_valid), 32'd1);
      chk("resp_other_valid", 32'(port ? a_rsp_valid : b_rsp_valid), 32'd0);
      chk("resp_rdata", rd, exp_w);
      chk("resp_byte", 32'(by), 32'(we ? 8'h00 : be_byte(exp_w, bs)));
      @(posedge clk); #1;
      if (we) ref_mem[addr] = wd;
      ref_last = port;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd, tmp;
      logic [7:0]  by;
      logic [15:0] own_addr;
      bit          exp_own;
      for (int i = 0; i < 65536; i++) begin
         tmp = $urandom;
         mem[i] = tmp;
         ref_mem[i] = tmp;
      end
      mem[16'h0010] = 32'h0123_4567;
      ref_mem[16'h0010] = 32'h0123_4567;
      ref_last = 1'b1;

      // Reset state
      #3;
      chk("rst_a_ready", 32'(a_req_ready), 32'd0);
      chk("rst_a_rsp_valid", 32'(a_rsp_valid), 32'd0);
      chk("rst_b_rsp_valid", 32'(b_rsp_valid), 32'd0);
      chk("rst_mem_we_re", 32'({mem_we, mem_re}), 32'd0);
      chk("rst_mem_addr", 32'(mem_addr), 32'd0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // Reset during ISSUE of a write aborts it
      set_req(1'b0, 1'b1, 1'b1, 16'h0010, 2'b00, 32'hDEAD_BEEF);
      @(negedge clk);
      chk("abort_accept", 32'(a_req_ready), 32'd1);
      @(posedge clk); #1;
      set_req(1'b0, 1'b0, 1'b0, 16'h0, 2'b00, 32'h0);
      chk("abort_issue_we", 32'(mem_we), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("abort_mem_we_re", 32'({mem_we, mem_re}), 32'd0);
      chk("abort_mem_addr", 32'(mem_addr), 32'd0);
      chk("abort_mem_data", mem_data, 32'd0);
      chk("abort_rsp_valid", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      ref_last = 1'b1;
      @(posedge clk); #1;
      txn(1'b0, 1'b0, 16'h0010, 2'b00, 32'h0, rd, by);
      chk("abort_not_written", rd, 32'h0123_4567);

      // Single write then read
      txn(1'b0, 1'b1, 16'h0005, 2'b00, 32'h1122_3344, rd, by);
      chk("wr_rsp_rdata_zero", rd, 32'h0);
      txn(1'b0, 1'b0, 16'h0005, 2'b01, 32'h0, rd, by);
      chk("rd_word", rd, 32'h1122_3344);
      chk("rd_byte01", 32'(by), 32'h22);

      // Byte lanes at top address
      txn(1'b1, 1'b1, 16'hFFFF, 2'b10, 32'hA1B2_C3D4, rd, by);
      chk("lane_wr_byte_zero", 32'(by), 32'h0);
      for (int l = 0; l < 4; l++) begin
         txn(l[0], 1'b0, 16'hFFFF, 2'(l), 32'h0, rd, by);
         chk("lane_byte", 32'(by), 32'(8'hA1 + 8'(l) * 8'h11));
      end

      // Contention: both ports continuously valid with reads
      set_req(1'b0, 1'b1, 1'b0, 16'($urandom), 2'($urandom), 32'h0);
      set_req(1'b1, 1'b1, 1'b0, 16'($urandom), 2'($urandom), 32'h0);
      exp_own = 1'b0;
      own_addr = 16'h0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (c % 3 == 0) begin
            exp_own = RR ? !ref_last : 1'b0;
            chk("cont_a_ready", 32'(a_req_ready), 32'(exp_own == 1'b0));
            chk("cont_b_ready", 32'(b_req_ready), 32'(exp_own == 1'b1));
            own_addr = exp_own ? b_req_addr : a_req_addr;
            ref_last = exp_own;
         end else begin
            chk("cont_no_ready", 32'({a_req_ready, b_req_ready}), 32'd0);
         end
         if (c % 3 == 2) begin
            chk("cont_rsp_valid", 32'({a_rsp_valid, b_rsp_valid}), exp_own ? 32'd1 : 32'd2);
            chk("cont_rsp_rdata", exp_own ? b_rsp_rdata : a_rsp_rdata, ref_mem[own_addr]);
         end else begin
            chk("cont_no_rsp", 32'({a_rsp_valid, b_rsp_valid}), 32'd0);
         end
         @(posedge clk); #1;
         if (c % 3 == 0) begin
            if (exp_own) b_req_addr = 16'($urandom);
            else a_req_addr = 16'($urandom);
         end
      end
      // A drops; B wins the very next IDLE
      a_req_valid = 1'b0;
      @(negedge clk);
      chk("cont_b_after_a", 32'({a_req_ready, b_req_ready}), 32'd1);
      own_addr = b_req_addr;
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      ref_last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("cont_b_rsp", b_rsp_rdata, ref_mem[own_addr]);
      @(posedge clk); #1;

      // Response backpressure on B with A pending
      b_rsp_ready = 1'b0;
      set_req(1'b1, 1'b1, 1'b0, 16'h00FF, 2'b11, 32'h0);
      @(negedge clk);
      chk("bp_b_accept", 32'(b_req_ready), 32'd1);
      @(posedge clk); #1;
      b_req_valid = 1'b0;
      own_addr = 16'($urandom);
      set_req(1'b0, 1'b1, 1'b0, own_addr, 2'b00, 32'h0);
      @(negedge clk);
      chk("bp_issue_a_ready", 32'(a_req_ready), 32'd0);
      @(posedge clk);
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("bp_hold_valid", 32'(b_rsp_valid), 32'd1);
         chk("bp_hold_rdata", b_rsp_rdata, ref_mem[16'h00FF]);
         chk("bp_hold_byte", 32'(b_rsp_byte), 32'(be_byte(ref_mem[16'h00FF], 2'b11)));
         chk("bp_a_blocked", 32'(a_req_ready), 32'd0);
         @(posedge clk);
      end
      #1 b_rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_a_blocked_hs", 32'(a_req_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      chk("bp_a_ready_after", 32'(a_req_ready), 32'd1);
      @(posedge clk); #1;
      a_req_valid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk("bp_a_rsp", a_rsp_rdata, ref_mem[own_addr]);
      @(posedge clk); #1;
      ref_last = 1'b0;

      // Randomized isolated traffic
      for (int i = 0; i < 24; i++) begin
         txn(1'($urandom), 1'($urandom), 16'($urandom), 2'($urandom), $urandom, rd, by);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
